smc_frame_loader: RTL
=====================

# smc_frame_loader

Sequential front end for the combinational Super MOSFET Calculator (SMC). It accepts one transistor's parameters per handshake beat, assembles a six-transistor frame plus mode, and holds that frame on the SMC input pins. After a programmable settle time it captures the SMC's `out_n` result and presents it downstream on a valid/ready interface. It sits between a narrow upstream stream and the SMC instance, turning the calculator into a pipelined, flow-controlled stage.

## Interface
- `SETTLE_CYCLES`, default 1: clock edges between the last beat and result capture. Legal range 1..15.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  upstream beat valid.
- `in_ready`  output  1  loader can accept a beat.
- `mode_in`  input  2  frame mode, sampled on beat 0 only.
- `W_in`, `V_GS_in`, `V_DS_in`  input  3 each  transistor parameters for the current beat.
- `mode`  output  2  registered mode, to SMC.
- `W_k`, `V_GS_k`, `V_DS_k` (k=0..5)  output  3 each  registered transistor k parameters, to SMC.
- `out_n_in`  input  10  SMC result (combinational from the above).
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `out_data`  output  10  captured result.
- `frames_done`  output  8  completed-frame counter.
- `err`  output  1  frame range error (see Configuration).

## Operation
- FSM states: COLLECT, SETTLE, OUT.
- COLLECT:
  - `in_ready`=1.
  - A beat is accepted on `in_valid & in_ready`. The beat counter `beat` (3 bits, 0..5) selects which `W_k`/`V_GS_k`/`V_DS_k` register is written.
  - Beat 0 also writes `mode` from `mode_in`.
  - Accepting beat 5 sets `beat` to 0, loads the settle counter with `SETTLE_CYCLES`, and moves to SETTLE.
- SETTLE:
  - `in_ready`=0.
  - The counter decrements each edge. On the edge where it reaches 0, `out_data` is loaded from `out_n_in`, `out_valid` is set, and the FSM moves to OUT.
- OUT:
  - `in_ready`=0; `out_valid`=1. `out_data` and all SMC-side registers hold stable.
  - On `out_valid & out_ready`, the FSM moves to COLLECT, and `frames_done` increments, wrapping 255→0.
- SMC-side registers change only when their beat is accepted. Unwritten positions keep the previous frame's values.
- `in_valid` while `in_ready`=0 is ignored. No beat is consumed.

## Timing
- Reset values:
  - state COLLECT, `beat`=0.
  - `in_ready`=1 (asserted directly after reset).
  - `out_valid`=0, `out_data`=0, `mode`=0, all `W_k`/`V_GS_k`/`V_DS_k`=0.
  - `frames_done`=0, `err`=0.
- Beat 5 accepted at edge E: `out_valid` rises after edge E+`SETTLE_CYCLES`. With the default of 1, that is E+1.
- The earliest next beat-0 acceptance is the edge after the output handshake edge. No overlap between frames.
- Beat acceptance is not required on consecutive cycles. Gaps in `in_valid` stall COLLECT with no timeout.
- Reset asserted mid-frame or mid-OUT: all state returns to its reset value asynchronously. A partial frame is discarded and no result is emitted.
- `out_ready` held high in OUT: the handshake completes on the first OUT edge, so `out_valid` lasts exactly one cycle.

## Configuration
- `SMC_LOADER_RANGE_CHECK_EN` defined:
  - A beat with `W_in`==0 sets a per-frame error flag.
  - At capture, `err` is loaded with that flag and is valid alongside `out_valid`, with the same hold behaviour as `out_data`.
  - If the flag is set, `out_data` is forced to 10'h3FF instead of `out_n_in`.
  - The flag clears on the next beat 0 accepted.
- Macro undefined: no check is performed. `err` is tied to 0, and `out_data` is always `out_n_in` at capture.

## Test plan
- Reset, then six beats (W=1..6, V_GS=3, V_DS=2, mode_in=2'b01 on beat 0) with bench `out_n_in`=10'h155 → `mode`=01, `W_5`=6, `out_valid` rises after edge E+1, `out_data`=10'h155, `frames_done`=1 after handshake.
- Same frame with `in_valid` toggling every other cycle and `out_ready` low for 4 cycles → all six beats land in correct slots. `out_valid`/`out_data` stay stable for the 4 cycles. `in_ready`=0 throughout SETTLE/OUT, and extra `in_valid` pulses are ignored.
- `SETTLE_CYCLES`=4, `out_n_in` changed from 10'h0AA to 10'h2C3 two edges after beat 5 → captured `out_data`=10'h2C3 at E+4.
- Reset asserted after beat 3 → `in_ready`=1, `W_0`..`W_5`=0, `out_valid`=0. The next six beats form a fresh frame.
- 256 frames back-to-back with `out_ready`=1 → `frames_done` wraps to 0, and each `out_valid` is exactly 1 cycle.
- With `SMC_LOADER_RANGE_CHECK_EN`: beat 2 has W_in=0 → `out_data`=10'h3FF, `err`=1. The next clean frame gives `err`=0.

Source files
------------

// File: rtl/smc_frame_loader_if.sv
// smc_frame_loader_if: upstream beat stream and downstream result stream of
// the SMC frame loader.
//   in_valid/in_ready     : beat handshake, master -> loader
//   mode_in               : frame mode, meaningful on beat 0 only
//   W_in/V_GS_in/V_DS_in  : one transistor's parameters per beat
//   out_valid/out_ready   : result handshake, loader -> master
//   out_data              : captured SMC result
interface smc_frame_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode_in;
  logic [2:0] W_in;
  logic [2:0] V_GS_in;
  logic [2:0] V_DS_in;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;

  modport master (
    output in_valid, mode_in, W_in, V_GS_in, V_DS_in, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, mode_in, W_in, V_GS_in, V_DS_in, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/smc_frame_loader.sv
// smc_frame_loader: sequential front end for the combinational Super MOSFET
// Calculator. Collects six transistor beats plus a mode into registers that
// drive the SMC pins, waits SETTLE_CYCLES edges, captures the SMC result and
// offers it downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   bus (slave)       : beat stream in, result stream out
//   mode              : registered frame mode to the SMC
//   W_k/V_GS_k/V_DS_k : registered transistor k parameters to the SMC, k=0..5
//   out_n_in          : combinational SMC result
//   frames_done       : completed-frame counter, wraps 255 -> 0
//   err               : frame range error, valid alongside out_valid
//
// Build option: define SMC_LOADER_RANGE_CHECK_EN to flag frames containing a
// beat with W_in == 0 (result forced to all ones, err set). Without it err is
// tied low and the SMC result is passed through unchanged.
module smc_frame_loader #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  smc_frame_loader_if.slave    bus,
  output logic [1:0]           mode,
  output logic [2:0]           W_0,
  output logic [2:0]           V_GS_0,
  output logic [2:0]           V_DS_0,
  output logic [2:0]           W_1,
  output logic [2:0]           V_GS_1,
  output logic [2:0]           V_DS_1,
  output logic [2:0]           W_2,
  output logic [2:0]           V_GS_2,
  output logic [2:0]           V_DS_2,
  output logic [2:0]           W_3,
  output logic [2:0]           V_GS_3,
  output logic [2:0]           V_DS_3,
  output logic [2:0]           W_4,
  output logic [2:0]           V_GS_4,
  output logic [2:0]           V_DS_4,
  output logic [2:0]           W_5,
  output logic [2:0]           V_GS_5,
  output logic [2:0]           V_DS_5,
  input  logic [9:0]           out_n_in,
  output logic [7:0]           frames_done,
  output logic                 err
);

  localparam int unsigned NUM_T  = 6;
  localparam int unsigned PRM_W  = 3;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned FD_W   = 8;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_OUT     = 2'd2;

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(NUM_T - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  logic [1:0]                       state_q, state_d;
  logic [BEAT_W-1:0]                beat_q, beat_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             in_ready_q, in_ready_d;
  logic                             out_valid_q, out_valid_d;
  logic [DATA_W-1:0]                out_data_q, out_data_d;
  logic [MODE_W-1:0]                mode_q, mode_d;
  logic [NUM_T-1:0][PRM_W-1:0]      w_q, w_d;
  logic [NUM_T-1:0][PRM_W-1:0]      gs_q, gs_d;
  logic [NUM_T-1:0][PRM_W-1:0]      ds_q, ds_d;
  logic [FD_W-1:0]                  fd_q, fd_d;
  logic                             beat_fire_c;
  logic [DATA_W-1:0]                cap_data_c;

`ifdef SMC_LOADER_RANGE_CHECK_EN
  localparam logic [DATA_W-1:0] ERR_DATA = '1;

  logic flag_q, flag_d;
  logic err_q, err_d;
`endif

  // A beat is consumed only while the loader advertises ready.
  assign beat_fire_c = bus.in_valid & in_ready_q;

  // Value loaded into out_data when the settle window closes.
`ifdef SMC_LOADER_RANGE_CHECK_EN
  assign cap_data_c = flag_q ? ERR_DATA : out_n_in;
`else
  assign cap_data_c = out_n_in;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mode_d      = mode_q;
    w_d         = w_q;
    gs_d        = gs_q;
    ds_d        = ds_q;
    fd_d        = fd_q;
`ifdef SMC_LOADER_RANGE_CHECK_EN
    flag_d      = flag_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_COLLECT: begin
        if (beat_fire_c) begin
          w_d[beat_q]  = bus.W_in;
          gs_d[beat_q] = bus.V_GS_in;
          ds_d[beat_q] = bus.V_DS_in;
          if (beat_q == '0) begin
            mode_d = bus.mode_in;
          end
`ifdef SMC_LOADER_RANGE_CHECK_EN
          // Beat 0 starts a fresh frame, so the sticky flag restarts there.
          flag_d = ((beat_q == '0) ? 1'b0 : flag_q) | (bus.W_in == '0);
`endif
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            cnt_d   = SETTLE_LOAD;
            state_d = ST_SETTLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Capture on the edge where the counter reaches zero; <= also
        // protects against an out-of-range load of zero.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d       = '0;
          out_data_d  = cap_data_c;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
`ifdef SMC_LOADER_RANGE_CHECK_EN
          err_d       = flag_q;
`endif
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fd_d        = fd_q + FD_W'(1);
          state_d     = ST_COLLECT;
        end
      end

      default: begin
        state_d     = ST_COLLECT;
        beat_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // in_ready is registered and tracks the state being entered.
  assign in_ready_d = (state_d == ST_COLLECT);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      beat_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mode_q      <= '0;
      w_q         <= '0;
      gs_q        <= '0;
      ds_q        <= '0;
      fd_q        <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mode_q      <= mode_d;
      w_q         <= w_d;
      gs_q        <= gs_d;
      ds_q        <= ds_d;
      fd_q        <= fd_d;
    end
  end

`ifdef SMC_LOADER_RANGE_CHECK_EN
  // Range-check flag and reported error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign mode          = mode_q;
  assign frames_done   = fd_q;

  assign W_0    = w_q[0];
  assign V_GS_0 = gs_q[0];
  assign V_DS_0 = ds_q[0];
  assign W_1    = w_q[1];
  assign V_GS_1 = gs_q[1];
  assign V_DS_1 = ds_q[1];
  assign W_2    = w_q[2];
  assign V_GS_2 = gs_q[2];
  assign V_DS_2 = ds_q[2];
  assign W_3    = w_q[3];
  assign V_GS_3 = gs_q[3];
  assign V_DS_3 = ds_q[3];
  assign W_4    = w_q[4];
  assign V_GS_4 = gs_q[4];
  assign V_DS_4 = ds_q[4];
  assign W_5    = w_q[5];
  assign V_GS_5 = gs_q[5];
  assign V_DS_5 = ds_q[5];

endmodule
